// File: rtl/hockey_input_sched_pkg.sv
// rtl/hockey_input_sched_pkg.sv - shared constants and types for the hockey input scheduler
package hockey_input_sched_pkg;

    localparam logic [1:0] DIR_STRAIGHT = 2'd0;
    localparam logic [1:0] DIR_UP       = 2'd1;
    localparam logic [1:0] DIR_DOWN     = 2'd2;
    localparam logic [1:0] DIR_ILLEGAL  = 2'd3;

    localparam logic [2:0] Y_MAX = 3'd4;

    localparam logic PLAYER_A = 1'b0;
    localparam logic PLAYER_B = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } offer_state_t;

    function automatic logic hit_legal(input logic [2:0] y, input logic [1:0] dir);
        return (y <= Y_MAX) && (dir != DIR_ILLEGAL);
    endfunction

endpackage

// File: rtl/hockey_input_sched_btn_conditioner.sv
// rtl/hockey_input_sched_btn_conditioner.sv - button synchroniser, debouncer and press pulse
module btn_conditioner #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          level;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronised input disagrees with the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            meta  <= raw;
            sync  <= meta;
            press <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync;
                cnt   <= '0;
                press <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hockey_input_sched.sv
// rtl/hockey_input_sched.sv - hit capture, aging, round-robin offer and game tick
module hockey_input_sched
    import hockey_input_sched_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 16,
    parameter int AGE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_a_raw,
    input  logic       btn_b_raw,
    input  logic [2:0] y_a,
    input  logic [2:0] y_b,
    input  logic [1:0] dir_a,
    input  logic [1:0] dir_b,
    input  logic       core_ready,
    input  logic       req_ack,
    output logic       tick,
    output logic       req_valid,
    output logic       req_player,
    output logic [2:0] req_y,
    output logic [1:0] req_dir,
    output logic       err_a,
    output logic       err_b
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int AW = $clog2(AGE_TICKS + 1);

    logic [1:0]         press;
    logic [1:0][2:0]    y_meta, y_sync;
    logic [1:0][1:0]    dir_meta, dir_sync;
    logic [TW-1:0]      tick_cnt;
    logic [1:0]         full;
    logic [1:0][2:0]    slot_y;
    logic [1:0][1:0]    slot_dir;
    logic [1:0][AW-1:0] slot_age;
    logic [1:0]         legal, offered, granted, expire, avail;
    logic               winner;
    logic               last_grant;
    offer_state_t       state;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_a (.clk(clk), .rst(rst), .raw(btn_a_raw), .press(press[0]));
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_b (.clk(clk), .rst(rst), .raw(btn_b_raw), .press(press[1]));

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_cnt <= '0;
        else     tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            legal[p]   = hit_legal(y_sync[p], dir_sync[p]);
            offered[p] = req_valid && (req_player == 1'(p));
            granted[p] = offered[p] && req_ack;
            expire[p]  = full[p] && tick && !offered[p] && (slot_age[p] == AW'(AGE_TICKS - 1));
            avail[p]   = full[p] && !expire[p];
        end
    end

    // Ties go to the player that did not win last; otherwise whichever slot is full.
    assign winner = (&avail) ? ~last_grant : avail[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_meta   <= '0;
            y_sync   <= '0;
            dir_meta <= '0;
            dir_sync <= '0;
            full     <= '0;
            slot_y   <= '0;
            slot_dir <= '0;
            slot_age <= '0;
            err_a    <= 1'b0;
            err_b    <= 1'b0;
        end else begin
            y_meta   <= {y_b, y_a};
            y_sync   <= y_meta;
            dir_meta <= {dir_b, dir_a};
            dir_sync <= dir_meta;
            err_a    <= press[0] && !legal[0];
            err_b    <= press[1] && !legal[1];
            for (int p = 0; p < 2; p++) begin
                if (granted[p] || expire[p]) begin
                    full[p] <= 1'b0;
                end else if (full[p] && tick && !offered[p]) begin
                    slot_age[p] <= slot_age[p] + 1'b1;
                end
                // A slot freed in this same cycle can take the new press.
                if (press[p] && legal[p] && (!full[p] || granted[p] || expire[p])) begin
                    full[p]     <= 1'b1;
                    slot_y[p]   <= y_sync[p];
                    slot_dir[p] <= dir_sync[p];
                    slot_age[p] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= PLAYER_B;
            req_valid  <= 1'b0;
            req_player <= PLAYER_A;
            req_y      <= '0;
            req_dir    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (core_ready && |avail) begin
                        req_valid  <= 1'b1;
                        req_player <= winner;
                        req_y      <= slot_y[winner];
                        req_dir    <= slot_dir[winner];
                        state      <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (req_ack) begin
                        req_valid  <= 1'b0;
                        last_grant <= req_player;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hockey_input_sched.sv
// tb/tb_hockey_input_sched.sv - scoreboard bench for hockey_input_sched
module tb_hockey_input_sched;
    import hockey_input_sched_pkg::*;

    localparam int TICK_DIV  = 8;
    localparam int DB_CYCLES = 4;
    localparam int AGE_TICKS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_a_raw = 1'b0, btn_b_raw = 1'b0;
    logic [2:0] y_a = '0, y_b = '0;
    logic [1:0] dir_a = '0, dir_b = '0;
    logic       core_ready = 1'b0, req_ack = 1'b0;
    logic       tick, req_valid, req_player, err_a, err_b;
    logic [2:0] req_y;
    logic [1:0] req_dir;

    typedef struct packed {
        logic       player;
        logic [2:0] y;
        logic [1:0] dir;
    } req_t;

    req_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   err_a_cnt = 0;
    int   err_b_cnt = 0;

    hockey_input_sched #(
        .TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES), .AGE_TICKS(AGE_TICKS)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_a_raw(btn_a_raw), .btn_b_raw(btn_b_raw),
        .y_a(y_a), .y_b(y_b), .dir_a(dir_a), .dir_b(dir_b),
        .core_ready(core_ready), .req_ack(req_ack),
        .tick(tick), .req_valid(req_valid), .req_player(req_player),
        .req_y(req_y), .req_dir(req_dir), .err_a(err_a), .err_b(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (err_a) err_a_cnt++;
        if (err_b) err_b_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for an offer, compares it to the scoreboard head, optionally holds it with core_ready low, then acks.
    task automatic wait_offer(input string tag, input int max_cyc, input int hold, input bit do_ack, output int lat);
        req_t exp;
        lat = 0;
        while (!req_valid && lat < max_cyc) begin
            step();
            lat++;
        end
        check_eq({tag, "_valid"}, req_valid, 1);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 0, 1);
        end else begin
            exp = exp_q.pop_front();
            check_eq({tag, "_req"}, {req_player, req_y, req_dir}, exp);
            if (hold > 0) begin
                core_ready = 1'b0;
                repeat (hold) step();
                check_eq({tag, "_hold"}, {req_valid, req_player, req_y, req_dir}, {1'b1, exp});
                core_ready = 1'b1;
            end
        end
        if (do_ack) begin
            req_ack = 1'b1;
            step();
            req_ack = 1'b0;
            check_eq({tag, "_drop"}, req_valid, 0);
        end
    endtask

    task automatic no_offer(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            step();
            if (req_valid) seen++;
        end
        check_eq(tag, seen, 0);
    endtask

    task automatic edges_to_tick(input string tag, input int exp);
        int n = 0;
        while (!tick && n < 4 * TICK_DIV) begin
            step();
            n++;
        end
        check_eq(tag, n, exp);
    endtask

    task automatic count_ticks(input string tag, input int want);
        int nt = 0;
        int cyc = 0;
        while (cyc < 20 * TICK_DIV) begin
            if (tick) nt++;
            if (nt == want) break;
            step();
            cyc++;
        end
        check_eq(tag, nt, want);
    endtask

    initial begin
        int lat;
        int e0;

        repeat (3) step();
        check_eq("reset_outputs", {tick, req_valid, req_player, req_y, req_dir, err_a, err_b}, 0);
        rst = 1'b0;
        edges_to_tick("first_tick", TICK_DIV - 1);

        // Single press: request appears DB_CYCLES+4 edges after the raw edge.
        core_ready = 1'b1;
        y_a = 3'd2; dir_a = DIR_UP;
        exp_q.push_back('{PLAYER_A, 3'd2, DIR_UP});
        btn_a_raw = 1'b1;
        wait_offer("single", 30, 3, 1'b1, lat);
        check_eq("single_latency", lat, DB_CYCLES + 4);
        btn_a_raw = 1'b0;
        no_offer("single_none", 12);

        // Bounce on B: glitches shorter than the debounce window produce no press.
        y_b = 3'd4; dir_b = DIR_DOWN;
        for (int i = 0; i < 5; i++) begin
            btn_b_raw = 1'b1; repeat (2) step();
            btn_b_raw = 1'b0; repeat (2) step();
        end
        btn_b_raw = 1'b1;
        exp_q.push_back('{PLAYER_B, 3'd4, DIR_DOWN});
        wait_offer("bounce", 40, 0, 1'b1, lat);
        no_offer("bounce_once", 30);
        btn_b_raw = 1'b0;
        repeat (12) step();
        check_eq("bounce_no_err", err_b_cnt, 0);

        // First tie after reset state: A, then B two cycles after the ack.
        y_a = 3'd1; dir_a = DIR_STRAIGHT; y_b = 3'd3; dir_b = DIR_UP;
        exp_q.push_back('{PLAYER_A, 3'd1, DIR_STRAIGHT});
        exp_q.push_back('{PLAYER_B, 3'd3, DIR_UP});
        btn_a_raw = 1'b1; btn_b_raw = 1'b1;
        wait_offer("tie1_first", 30, 0, 1'b1, lat);
        wait_offer("tie1_second", 10, 0, 1'b1, lat);
        check_eq("tie1_gap", lat, 1);
        btn_a_raw = 1'b0; btn_b_raw = 1'b0;
        repeat (12) step();

        // Grant A alone so the next tie goes to B.
        exp_q.push_back('{PLAYER_A, 3'd1, DIR_STRAIGHT});
        btn_a_raw = 1'b1;
        wait_offer("solo_a", 30, 0, 1'b1, lat);
        btn_a_raw = 1'b0;
        repeat (12) step();
        exp_q.push_back('{PLAYER_B, 3'd3, DIR_UP});
        exp_q.push_back('{PLAYER_A, 3'd1, DIR_STRAIGHT});
        btn_a_raw = 1'b1; btn_b_raw = 1'b1;
        wait_offer("tie2_first", 30, 0, 1'b1, lat);
        wait_offer("tie2_second", 10, 0, 1'b1, lat);
        btn_a_raw = 1'b0; btn_b_raw = 1'b0;
        repeat (12) step();

        // Illegal Y, then illegal DIR.
        e0 = err_a_cnt;
        y_a = 3'd5; dir_a = DIR_STRAIGHT;
        btn_a_raw = 1'b1;
        no_offer("bad_y_none", 14);
        check_eq("bad_y_err", err_a_cnt - e0, 1);
        btn_a_raw = 1'b0;
        no_offer("bad_y_release", 12);
        e0 = err_a_cnt;
        y_a = 3'd0; dir_a = DIR_ILLEGAL;
        btn_a_raw = 1'b1;
        no_offer("bad_dir_none", 14);
        check_eq("bad_dir_err", err_a_cnt - e0, 1);
        btn_a_raw = 1'b0;
        no_offer("bad_dir_release", 12);
        check_eq("no_err_b", err_b_cnt, 0);

        // Aging: after two ticks the slot survives.
        dir_a = DIR_STRAIGHT;
        core_ready = 1'b0;
        y_b = 3'd2; dir_b = DIR_STRAIGHT;
        btn_b_raw = 1'b1;
        repeat (DB_CYCLES + 3) step();
        count_ticks("age2_ticks", AGE_TICKS - 1);
        core_ready = 1'b1;
        exp_q.push_back('{PLAYER_B, 3'd2, DIR_STRAIGHT});
        wait_offer("age2_offer", 5, 0, 1'b1, lat);
        btn_b_raw = 1'b0;
        repeat (12) step();

        // Aging: the third tick discards the slot.
        core_ready = 1'b0;
        btn_b_raw = 1'b1;
        repeat (DB_CYCLES + 3) step();
        count_ticks("age3_ticks", AGE_TICKS);
        step();
        core_ready = 1'b1;
        no_offer("age3_expired", 12);
        btn_b_raw = 1'b0;
        repeat (12) step();

        // Reset while a request is offered.
        y_a = 3'd3; dir_a = DIR_DOWN;
        exp_q.push_back('{PLAYER_A, 3'd3, DIR_DOWN});
        btn_a_raw = 1'b1;
        wait_offer("rst_offer", 30, 0, 1'b0, lat);
        #4;
        rst = 1'b1;
        btn_a_raw = 1'b0;
        #1;
        check_eq("rst_outputs", {tick, req_valid, req_player, req_y, req_dir, err_a, err_b}, 0);
        repeat (2) step();
        rst = 1'b0;
        edges_to_tick("rst_first_tick", TICK_DIV - 1);
        no_offer("rst_lost", 20);
        check_eq("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
